// File: rtl/ram_slot_sched.sv
// Per-slot SDRAM scheduler for the REU: power-up init sequence, DMA read/write slots and
// auto-refresh with bounded debt. All state advances on the falling edge of PHI2.
module ram_slot_sched #(
  parameter int unsigned REFI_CYC = 15,
  parameter int unsigned DEBT_MAX = 7,
  parameter int unsigned INIT_REF = 8
) (
  input  logic PHI2,
  input  logic Reset,
  input  logic RAMRD,
  input  logic RAMWR,
  output logic SlotRD,
  output logic SlotWR,
  output logic SlotREF,
  output logic SlotPC,
  output logic SlotMRS,
  output logic Ready,
  output logic Stall,
  output logic Overrun
);

  localparam int unsigned TimerW = $clog2(REFI_CYC);
  localparam int unsigned DebtW  = $clog2(DEBT_MAX + 1);
  localparam int unsigned InitW  = (INIT_REF > 1) ? $clog2(INIT_REF) : 1;

  typedef enum logic [1:0] {StInitPc, StInitRef, StInitMrs, StRun} state_e;

  state_e             state_q, state_d;
  logic [InitW-1:0]   init_cnt_q, init_cnt_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [DebtW-1:0]   debt_q, debt_d;
  logic               rd_d, wr_d, ref_d, pc_d, mrs_d, ready_d, stall_d, overrun_d;
  logic               wrap, issue_ref, req;

  assign req = RAMRD | RAMWR;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    timer_d    = '0;
    debt_d     = debt_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    ref_d      = 1'b0;
    pc_d       = 1'b0;
    mrs_d      = 1'b0;
    ready_d    = 1'b0;
    stall_d    = 1'b0;
    overrun_d  = Overrun;
    wrap       = 1'b0;
    issue_ref  = 1'b0;

    unique case (state_q)
      StInitPc: begin
        pc_d       = 1'b1;
        init_cnt_d = '0;
        state_d    = StInitRef;
      end
      StInitRef: begin
        ref_d = 1'b1;
        if (init_cnt_q == InitW'(INIT_REF - 1)) begin
          state_d = StInitMrs;
        end else begin
          init_cnt_d = init_cnt_q + InitW'(1);
        end
      end
      StInitMrs: begin
        mrs_d   = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        ready_d = 1'b1;
        wrap    = (timer_q == TimerW'(REFI_CYC - 1));
        timer_d = wrap ? '0 : timer_q + TimerW'(1);

        // Forced refresh outranks any request; a request in that slot is lost.
        if (debt_q == DebtW'(DEBT_MAX)) begin
          issue_ref = 1'b1;
          if (req) overrun_d = 1'b1;
        end else if (RAMRD) begin
          rd_d = 1'b1;
          if (RAMWR) overrun_d = 1'b1;
        end else if (RAMWR) begin
          wr_d = 1'b1;
        end else if (debt_q != '0) begin
          issue_ref = 1'b1;
        end
        ref_d = issue_ref;

        if (issue_ref && !wrap) begin
          debt_d = debt_q - DebtW'(1);
        end else if (wrap && !issue_ref && (debt_q != DebtW'(DEBT_MAX))) begin
          debt_d = debt_q + DebtW'(1);
        end
        stall_d = (debt_d >= DebtW'(DEBT_MAX - 1));
      end
      default: state_d = StInitPc;
    endcase

    if ((state_q != StRun) && req) overrun_d = 1'b1;
  end

  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state_q    <= StInitPc;
      init_cnt_q <= '0;
      timer_q    <= '0;
      debt_q     <= '0;
      SlotRD     <= 1'b0;
      SlotWR     <= 1'b0;
      SlotREF    <= 1'b0;
      SlotPC     <= 1'b0;
      SlotMRS    <= 1'b0;
      Ready      <= 1'b0;
      Stall      <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      timer_q    <= timer_d;
      debt_q     <= debt_d;
      SlotRD     <= rd_d;
      SlotWR     <= wr_d;
      SlotREF    <= ref_d;
      SlotPC     <= pc_d;
      SlotMRS    <= mrs_d;
      Ready      <= ready_d;
      Stall      <= stall_d;
      Overrun    <= overrun_d;
    end
  end

endmodule
